param_deserializer: RTL and testbench

- Parametrised serial-to-parallel converter for the UART receive path. It is the next generation of the fixed 8-bit LSB-first deserializer.
- Assembles oversampled bits into a word of run-time length 1..DATA_WIDTH, with selectable bit order.
- Publishes each completed word atomically with a one-cycle valid pulse and its XOR parity.
- Sits between the RX FSM/edge-bit counter/data sampler and the parity and stop checkers.

---
 rtl/param_deserializer_if.sv | 27 ++
 rtl/param_deserializer.sv | 102 ++++++++++
 tb/tb_param_deserializer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/param_deserializer_if.sv
// Bus between the RX path and param_deserializer: sampler/FSM controls in, completed word out.
interface param_deserializer_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
);
  logic                      sampled_bit;
  logic                      deser_en;
  logic [PRESCALE_WIDTH-1:0] edge_cnt;
  logic [PRESCALE_WIDTH-1:0] Prescale;
  logic [3:0]                data_len;
  logic                      msb_first;
  logic                      clear;
  logic [DATA_WIDTH-1:0]     P_DATA;
  logic                      data_valid;
  logic                      par_bit;
  logic                      busy;

  modport master (
    output sampled_bit, deser_en, edge_cnt, Prescale, data_len, msb_first, clear,
    input  P_DATA, data_valid, par_bit, busy
  );

  modport slave (
    input  sampled_bit, deser_en, edge_cnt, Prescale, data_len, msb_first, clear,
    output P_DATA, data_valid, par_bit, busy
  );
endinterface

// File: rtl/param_deserializer.sv
// Serial-to-parallel converter for the UART RX path: run-time length, selectable bit order,
// atomic word publish with one-cycle valid pulse and XOR parity.
//   state | meaning
//   IDLE  | waiting for the first bit of a frame
//   SHIFT | frame in progress, bit_cnt bits accepted
module param_deserializer #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                 CLK,
  input  logic                 RST,
  param_deserializer_if.slave  bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [3:0] MAX_LEN = 4'(DATA_WIDTH);

  state_t                state;
  logic [3:0]            bit_cnt;
  logic [3:0]            len_q;
  logic                  msb_q;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  acc;
  logic [DATA_WIDTH-1:0] p_data_q;
  logic                  par_q;
  logic                  valid_q;

  logic                  strobe;
  logic [3:0]            eff_len;
  logic [3:0]            cur_len;
  logic                  cur_msb;
  logic [3:0]            cur_cnt;
  logic [3:0]            wr_idx;
  logic [DATA_WIDTH-1:0] word_nxt;
  logic                  acc_nxt;
  logic                  last;

  assign strobe  = bus.deser_en && (bus.edge_cnt == bus.Prescale - PRESCALE_WIDTH'(1));
  assign eff_len = (bus.data_len == 4'd0 || bus.data_len > MAX_LEN) ? MAX_LEN : bus.data_len;

  // In IDLE the frame parameters come straight from the inputs; in SHIFT from the latched copy.
  always_comb begin
    cur_len  = (state == IDLE) ? eff_len       : len_q;
    cur_msb  = (state == IDLE) ? bus.msb_first : msb_q;
    cur_cnt  = (state == IDLE) ? 4'd0          : bit_cnt;
    wr_idx   = cur_msb ? (cur_len - 4'd1 - cur_cnt) : cur_cnt;
    word_nxt = (state == IDLE) ? '0 : shreg;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (4'(i) == wr_idx) word_nxt[i] = bus.sampled_bit;
    end
    acc_nxt  = (state == IDLE) ? bus.sampled_bit : (acc ^ bus.sampled_bit);
    last     = (cur_cnt == cur_len - 4'd1);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      len_q    <= '0;
      msb_q    <= 1'b0;
      shreg    <= '0;
      acc      <= 1'b0;
      p_data_q <= '0;
      par_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (bus.clear) begin
        state   <= IDLE;
        bit_cnt <= '0;
        shreg   <= '0;
        acc     <= 1'b0;
      end else if (strobe) begin
        if (last) begin
          p_data_q <= word_nxt;
          par_q    <= acc_nxt;
          valid_q  <= 1'b1;
          state    <= IDLE;
          bit_cnt  <= '0;
          shreg    <= '0;
          acc      <= 1'b0;
        end else begin
          shreg   <= word_nxt;
          acc     <= acc_nxt;
          bit_cnt <= cur_cnt + 4'd1;
          state   <= SHIFT;
          if (state == IDLE) begin
            len_q <= eff_len;
            msb_q <= bus.msb_first;
          end
        end
      end
    end
  end

  assign bus.P_DATA     = p_data_q;
  assign bus.par_bit    = par_q;
  assign bus.data_valid = valid_q;
  assign bus.busy       = (state == SHIFT);

endmodule

// File: tb/tb_param_deserializer.sv
// Directed plus random stimulus for param_deserializer, checked every cycle against a
// frame-level reference model built from bit lists.
module tb_param_deserializer;
  localparam int DW = 8;
  localparam int PW = 6;

  logic CLK;
  logic RST;
  param_deserializer_if #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) bus ();

  param_deserializer #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit      m_bits[$];
  bit      m_active = 0;
  int      m_len = 0;
  bit      m_msb = 0;
  int      m_pdata = 0;
  bit      m_par = 0;
  bit      m_valid = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int strobe_edge();
    return (int'(bus.Prescale) + (1 << PW) - 1) % (1 << PW);
  endfunction

  task automatic model_reset();
    m_bits.delete();
    m_active = 0;
    m_pdata  = 0;
    m_par    = 0;
    m_valid  = 0;
  endtask

  task automatic model_step();
    bit stb;
    int word;
    int ones;
    stb = bus.deser_en && (int'(bus.edge_cnt) == strobe_edge());
    m_valid = 0;
    if (bus.clear) begin
      m_bits.delete();
      m_active = 0;
    end else if (stb) begin
      if (!m_active) begin
        m_len    = (bus.data_len == 0 || int'(bus.data_len) > DW) ? DW : int'(bus.data_len);
        m_msb    = bus.msb_first;
        m_active = 1;
        m_bits.delete();
      end
      m_bits.push_back(bus.sampled_bit);
      if (m_bits.size() == m_len) begin
        word = 0;
        ones = 0;
        foreach (m_bits[j]) begin
          if (m_bits[j]) begin
            word += 1 << (m_msb ? (m_len - 1 - j) : j);
            ones++;
          end
        end
        m_pdata  = word;
        m_par    = bit'(ones % 2);
        m_valid  = 1;
        m_active = 0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".P_DATA"}, 32'(bus.P_DATA), 32'(m_pdata));
    check({tag, ".par_bit"}, 32'(bus.par_bit), 32'(m_par));
    check({tag, ".data_valid"}, 32'(bus.data_valid), 32'(m_valid));
    check({tag, ".busy"}, 32'(bus.busy), 32'(m_active));
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge CLK);
    #1;
    check_outputs(tag);
  endtask

  task automatic send_bit(input bit b);
    int v;
    repeat ($urandom_range(0, 2)) begin
      v = $urandom_range(0, (1 << PW) - 1);
      if (v == strobe_edge()) v = (v + 1) % (1 << PW);
      bus.edge_cnt    = PW'(v);
      bus.deser_en    = $urandom_range(0, 1) == 1;
      bus.sampled_bit = $urandom_range(0, 1) == 1;
      cycle("gap");
    end
    bus.deser_en    = 1'b1;
    bus.edge_cnt    = PW'(strobe_edge());
    bus.sampled_bit = b;
    cycle("strobe");
    bus.deser_en    = 1'b0;
  endtask

  // bits[j] is the j-th bit on the wire
  task automatic send_frame(input logic [14:0] bits, input int n);
    for (int j = 0; j < n; j++) send_bit(bits[j]);
  endtask

  task automatic check_word(input string tag, input int word, input bit par);
    check({tag, ".word"}, 32'(bus.P_DATA), 32'(word));
    check({tag, ".par"}, 32'(bus.par_bit), 32'(par));
    check({tag, ".valid"}, 32'(bus.data_valid), 32'd1);
  endtask

  initial begin
    RST             = 1'b0;
    bus.sampled_bit = 1'b0;
    bus.deser_en    = 1'b0;
    bus.edge_cnt    = '0;
    bus.Prescale    = PW'(8);
    bus.data_len    = 4'd8;
    bus.msb_first   = 1'b0;
    bus.clear       = 1'b0;
    model_reset();
    #12;
    check_outputs("reset");
    RST = 1'b1;
    cycle("post_reset");

    // A5, LSB-first then MSB-first (palindrome)
    send_frame(15'h00A5, 8);
    check_word("a5_lsb", 'hA5, 0);
    cycle("a5_idle");
    check("a5_busy_after", 32'(bus.busy), 32'd0);
    bus.msb_first = 1'b1;
    send_frame(15'h00A5, 8);
    check_word("a5_msb", 'hA5, 0);

    // wire order 1,1,0,0,0,0,0,0
    bus.msb_first = 1'b0;
    send_frame(15'h0003, 8);
    check_word("b03_lsb", 'h03, 0);
    bus.msb_first = 1'b1;
    send_frame(15'h0003, 8);
    check_word("bc0_msb", 'hC0, 0);

    // short and default lengths
    bus.msb_first = 1'b0;
    bus.data_len  = 4'd5;
    send_frame(15'h0017, 5);
    check_word("len5", 'h17, 0);
    bus.data_len  = 4'd0;
    send_frame(15'h00FF, 8);
    check_word("len0", 'hFF, 0);
    bus.data_len  = 4'd8;

    // abort after 3 bits; clear wins over a simultaneous strobe
    send_frame(15'h0007, 3);
    bus.clear       = 1'b1;
    bus.deser_en    = 1'b1;
    bus.edge_cnt    = PW'(7);
    bus.sampled_bit = 1'b1;
    cycle("clear");
    check("clear.valid", 32'(bus.data_valid), 32'd0);
    check("clear.hold", 32'(bus.P_DATA), 32'hFF);
    bus.clear    = 1'b0;
    bus.deser_en = 1'b0;
    send_frame(15'h003C, 8);
    check_word("after_clear", 'h3C, 0);

    // enable dropped mid-frame while edge_cnt sits on the strobe value
    send_frame(15'h0001, 3);
    bus.edge_cnt = PW'(7);
    bus.deser_en = 1'b0;
    repeat (20) cycle("en_low");
    check("en_low.busy", 32'(bus.busy), 32'd1);
    send_frame(15'h0015, 5);
    check_word("resume", 'hA9, 0);

    // Prescale = 0 strobes only at edge_cnt = all-ones
    bus.Prescale    = '0;
    bus.data_len    = 4'd2;
    bus.deser_en    = 1'b1;
    bus.sampled_bit = 1'b1;
    bus.edge_cnt    = PW'(62);
    cycle("ps0_62");
    check("ps0_62.busy", 32'(bus.busy), 32'd0);
    bus.edge_cnt    = PW'(63);
    cycle("ps0_63a");
    check("ps0_63a.busy", 32'(bus.busy), 32'd1);
    cycle("ps0_63b");
    check_word("ps0", 'h3, 0);
    bus.deser_en    = 1'b0;
    bus.Prescale    = PW'(8);

    // single-bit frames, second strobe lands on the first pulse
    bus.data_len    = 4'd1;
    send_bit(1'b1);
    check_word("len1", 'h1, 1);
    bus.deser_en    = 1'b1;
    bus.edge_cnt    = PW'(7);
    bus.sampled_bit = 1'b0;
    cycle("len1_b2b");
    check_word("len1_b2b", 'h0, 0);
    bus.deser_en    = 1'b0;
    cycle("len1_end");
    check("len1_end.valid", 32'(bus.data_valid), 32'd0);

    // asynchronous reset in the middle of a frame
    bus.data_len = 4'd8;
    send_frame(15'h0005, 4);
    RST = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    check("async_rst.word", 32'(bus.P_DATA), 32'd0);
    #2;
    RST = 1'b1;
    cycle("after_rst");

    // random traffic, including lengths above DATA_WIDTH and random clears
    for (int seg = 0; seg < 4; seg++) begin
      bus.Prescale = PW'($urandom_range(0, (1 << PW) - 1));
      for (int c = 0; c < 150; c++) begin
        bus.deser_en    = ($urandom_range(0, 3) != 0);
        bus.edge_cnt    = ($urandom_range(0, 1) == 1) ? PW'(strobe_edge())
                                                      : PW'($urandom_range(0, (1 << PW) - 1));
        bus.data_len    = 4'($urandom_range(0, 15));
        bus.msb_first   = $urandom_range(0, 1) == 1;
        bus.clear       = ($urandom_range(0, 39) == 0);
        bus.sampled_bit = $urandom_range(0, 1) == 1;
        cycle("rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
